// File: rtl/dsp_add3_arbiter.sv
// dsp_add3_arbiter: shares one pipelined 3-input DSP adder among NUM_REQ
// requesters. An INIT phase holds the adder in reset for LATENCY+1 cycles;
// RUN grants at most one requester per cycle. A {valid, id} tag pipeline
// of depth LATENCY follows each accepted operation, so its response is
// tagged with the requester that issued it.
//
// Build option: define DSP_ADD3_ARB_RR_EN for round-robin arbitration.
// Without it, fixed priority applies (lowest index wins) and there is no
// pointer register.
//
// Handshake: a requester transfers when req_valid[i] && req_ready[i] in the
// same cycle. req_ready is one-hot or zero and is derived from req_valid
// without looking at req_ready. The response stream (rsp_valid, rsp_id,
// rsp_result) has no backpressure; the consumer must take every beat.
module dsp_add3_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int LATENCY = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    flush,
  input  logic [NUM_REQ-1:0]                      req_valid,
  output logic [NUM_REQ-1:0]                      req_ready,
  input  logic [18*NUM_REQ-1:0]                   req_op0,
  input  logic [18*NUM_REQ-1:0]                   req_op1,
  input  logic [18*NUM_REQ-1:0]                   req_op2,
  input  logic [NUM_REQ-1:0]                      req_cin,
  output logic                                    dsp_reset,
  output logic [17:0]                             dsp_op0,
  output logic [17:0]                             dsp_op1,
  output logic [17:0]                             dsp_op2,
  output logic                                    dsp_cin,
  input  logic [47:0]                             dsp_result,
  output logic                                    rsp_valid,
  output logic [((NUM_REQ > 2) ? $clog2(NUM_REQ) : 1)-1:0] rsp_id,
  output logic [47:0]                             rsp_result,
  output logic                                    init_done,
  output logic                                    dbg_state
);

  localparam int ID_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam logic [3:0] CNT_LAST = 4'(LATENCY);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [ID_W-1:0] tag_id_q [LATENCY];
  logic [ID_W-1:0] tag_id_d [LATENCY];

  logic            grant_vld;
  logic [ID_W-1:0] grant_id;
  logic            grant_en;
  logic            rsp_fire;

`ifdef DSP_ADD3_ARB_RR_EN
  logic [ID_W-1:0] ptr_q, ptr_d;
`endif

  // Debug view of the FSM state for checkers.
  assign dbg_state = state_q;

  // Arbitration: pick the winning requester among the valid ones.
`ifdef DSP_ADD3_ARB_RR_EN
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_id  = '0;
    idx       = 0;
    // Walk from the farthest candidate back to the pointer so the one
    // closest to the pointer is the last assignment and therefore wins.
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (req_valid[idx]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(idx);
      end
    end
  end
`else
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    // Descending walk: the lowest valid index is assigned last and wins.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        grant_vld = 1'b1;
        grant_id  = ID_W'(i);
      end
    end
  end
`endif

  // A grant is only issued in RUN, and never in a reset or flush cycle.
  assign grant_en = grant_vld && (state_q == ST_RUN) && !reset && !flush;

  // Ready vector and operand steering to the shared adder.
  always_comb begin
    req_ready = '0;
    dsp_op0   = '0;
    dsp_op1   = '0;
    dsp_op2   = '0;
    dsp_cin   = 1'b0;
    if (grant_en) begin
      req_ready[grant_id] = 1'b1;
      dsp_op0 = req_op0[18*int'(grant_id) +: 18];
      dsp_op1 = req_op1[18*int'(grant_id) +: 18];
      dsp_op2 = req_op2[18*int'(grant_id) +: 18];
      dsp_cin = req_cin[grant_id];
    end
  end

  // Next state: INIT counts LATENCY+1 cycles, flush always restarts INIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == CNT_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_RUN: begin
        cnt_d = '0;
      end
      default: begin
        state_d = ST_INIT;
        cnt_d   = '0;
      end
    endcase
    if (flush) begin
      state_d = ST_INIT;
      cnt_d   = '0;
    end
  end

  // Tag pipeline: stage 0 captures this cycle's grant, flush empties it.
  always_comb begin
    tag_vld_d    = '0;
    tag_id_d[0]  = grant_id;
    tag_vld_d[0] = grant_en;
    for (int i = 1; i < LATENCY; i++) begin
      tag_vld_d[i] = tag_vld_q[i-1];
      tag_id_d[i]  = tag_id_q[i-1];
    end
    if (flush) begin
      tag_vld_d = '0;
    end
  end

`ifdef DSP_ADD3_ARB_RR_EN
  // Pointer moves just past the winner on an accept, otherwise holds.
  always_comb begin
    ptr_d = ptr_q;
    if (grant_en) begin
      if (grant_id == ID_W'(NUM_REQ - 1)) ptr_d = '0;
      else                                ptr_d = grant_id + ID_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`endif

  // State, counter and tag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_INIT;
      cnt_q     <= '0;
      tag_vld_q <= '0;
      for (int i = 0; i < LATENCY; i++) tag_id_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      tag_vld_q <= tag_vld_d;
      for (int i = 0; i < LATENCY; i++) tag_id_q[i] <= tag_id_d[i];
    end
  end

  // A response due in a reset or flush cycle belongs to a dropped op.
  assign rsp_fire = tag_vld_q[LATENCY-1] && !reset && !flush;

  // Status and response outputs.
  always_comb begin
    dsp_reset  = reset || (state_q == ST_INIT);
    init_done  = !reset && (state_q == ST_RUN);
    rsp_valid  = rsp_fire;
    rsp_id     = rsp_fire ? tag_id_q[LATENCY-1] : '0;
    rsp_result = rsp_fire ? dsp_result : '0;
  end

endmodule

// File: tb/tb_dsp_add3_arbiter.sv
// tb_dsp_add3_arbiter: directed and random stimulus for dsp_add3_arbiter
// with a behavioural model of the external adder and a scoreboard of
// expected responses keyed by the cycle in which each one is due.
module tb_dsp_add3_arbiter;

  localparam int N   = 4;
  localparam int L   = 2;
  localparam int IDW = 2;

  logic            clk = 1'b0;
  logic            reset, flush;
  logic [N-1:0]    req_valid, req_ready, req_cin;
  logic [18*N-1:0] req_op0, req_op1, req_op2;
  logic            dsp_reset, dsp_cin;
  logic [17:0]     dsp_op0, dsp_op1, dsp_op2;
  logic [47:0]     dsp_result;
  logic            rsp_valid;
  logic [IDW-1:0]  rsp_id;
  logic [47:0]     rsp_result;
  logic            init_done;
  logic            dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int run_at   = 1 << 30;
  int ptr      = 0;

  logic [47:0]    exp_q[$];
  logic [IDW-1:0] exp_id_q[$];
  int             exp_due_q[$];

  dsp_add3_arbiter #(.NUM_REQ(N), .LATENCY(L)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op0(req_op0), .req_op1(req_op1), .req_op2(req_op2), .req_cin(req_cin),
    .dsp_reset(dsp_reset), .dsp_op0(dsp_op0), .dsp_op1(dsp_op1),
    .dsp_op2(dsp_op2), .dsp_cin(dsp_cin), .dsp_result(dsp_result),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
    .init_done(init_done), .dbg_state(dbg_state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Signed 18-bit three-operand sum plus carry, as a 48-bit value.
  function automatic logic [47:0] add3(logic [17:0] a, logic [17:0] b,
                                       logic [17:0] c, logic ci);
    longint s;
    s = longint'($signed(a)) + longint'($signed(b)) + longint'($signed(c))
        + longint'(ci);
    return s[47:0];
  endfunction

  // External adder: result appears L cycles after operands are presented.
  logic [47:0] add_pipe [L];
  always @(posedge clk) begin
    add_pipe[0] <= add3(dsp_op0, dsp_op1, dsp_op2, dsp_cin);
    for (int i = 1; i < L; i++) add_pipe[i] <= add_pipe[i-1];
  end
  assign dsp_result = add_pipe[L-1];

  // Arbitration rule: which valid requester should win, or -1.
  function automatic int arb_pick(logic [N-1:0] v, int p);
    int r;
    r = -1;
`ifdef DSP_ADD3_ARB_RR_EN
    for (int k = 0; k < N; k++) if (r < 0 && v[(p + k) % N]) r = (p + k) % N;
`else
    for (int k = 0; k < N; k++) if (r < 0 && v[k]) r = k;
`endif
    return r;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic rand_fields();
    for (int i = 0; i < N; i++) begin
      req_op0[18*i +: 18] = 18'($urandom);
      req_op1[18*i +: 18] = 18'($urandom);
      req_op2[18*i +: 18] = 18'($urandom);
      req_cin[i]          = 1'($urandom);
    end
  endtask

  task automatic set_req(int i, logic [17:0] a, logic [17:0] b,
                         logic [17:0] c, logic ci);
    req_valid[i]        = 1'b1;
    req_op0[18*i +: 18] = a;
    req_op1[18*i +: 18] = b;
    req_op2[18*i +: 18] = c;
    req_cin[i]          = ci;
  endtask

  // One cycle: check outputs at the falling edge against the model, update
  // the model, then advance to 1 time unit after the next rising edge.
  task automatic tick();
    int          w;
    bit          running;
    logic [N-1:0] er;
    logic [17:0] e0, e1, e2;
    logic        ec;
    #4;
    running = !reset && (cyc >= run_at);
    w = running && !flush ? arb_pick(req_valid, ptr) : -1;
    er = '0; e0 = '0; e1 = '0; e2 = '0; ec = 1'b0;
    if (w >= 0) begin
      er[w] = 1'b1;
      e0 = req_op0[18*w +: 18];
      e1 = req_op1[18*w +: 18];
      e2 = req_op2[18*w +: 18];
      ec = req_cin[w];
    end
    chk("init_done", 64'(init_done), 64'(running));
    chk("dsp_reset", 64'(dsp_reset), 64'(!running));
    if (!reset) chk("dbg_state", 64'(dbg_state), 64'(running));
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("dsp_op0", 64'(dsp_op0), 64'(e0));
    chk("dsp_op1", 64'(dsp_op1), 64'(e1));
    chk("dsp_op2", 64'(dsp_op2), 64'(e2));
    chk("dsp_cin", 64'(dsp_cin), 64'(ec));
    if (!reset && !flush && exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
      chk("rsp_valid", 64'(rsp_valid), 64'd1);
      chk("rsp_id", 64'(rsp_id), 64'(exp_id_q[0]));
      chk("rsp_result", 64'(rsp_result), 64'(exp_q[0]));
      void'(exp_due_q.pop_front());
      void'(exp_id_q.pop_front());
      void'(exp_q.pop_front());
    end else begin
      chk("rsp_valid_idle", 64'(rsp_valid), 64'd0);
      chk("rsp_result_idle", 64'(rsp_result), 64'd0);
      if (!running) chk("rsp_id_idle", 64'(rsp_id), 64'd0);
    end
    if (reset || flush) begin
      exp_due_q.delete();
      exp_id_q.delete();
      exp_q.delete();
      run_at = cyc + L + 2;
      if (reset) ptr = 0;
    end else if (w >= 0) begin
      exp_due_q.push_back(cyc + L);
      exp_id_q.push_back(IDW'(w));
      exp_q.push_back(add3(e0, e1, e2, ec));
      ptr = (w + 1) % N;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Directed steps followed by random traffic.
  initial begin
    reset = 1'b1; flush = 1'b0; req_valid = '0;
    rand_fields();
    @(posedge clk);
    #1;

    // Reset with requests present, then the INIT window with requests held.
    req_valid = '1; tick();
    req_valid = N'($urandom); tick();
    reset = 1'b0;
    repeat (L + 1) begin rand_fields(); req_valid = '1; tick(); end
    req_valid = '0; tick();

    // Requester 1: 5 + (-3) + 10 + 1 = 13, tagged 1, two cycles later.
    rand_fields(); req_valid = '0;
    set_req(1, 18'd5, 18'h3FFFD, 18'd10, 1'b1); tick();
    req_valid = '0; tick();
    chk("r13_valid", 64'(rsp_valid), 64'd1);
    chk("r13_id", 64'(rsp_id), 64'd1);
    chk("r13_result", 64'(rsp_result), 64'd13);
    repeat (2) tick();

    // Operand extremes: 3*131071+1 then 3*(-131072).
    set_req(0, 18'h1FFFF, 18'h1FFFF, 18'h1FFFF, 1'b1); tick();
    req_valid = '0;
    set_req(0, 18'h20000, 18'h20000, 18'h20000, 1'b0); tick();
    req_valid = '0;
    chk("rmax_result", 64'(rsp_result), 64'(48'd393214));
    tick();
    chk("rmin_result", 64'(rsp_result), 64'(48'hFFFF_FFFA_0000));
    repeat (2) tick();

    // All requesters valid continuously: back-to-back grants and responses.
    repeat (8) begin rand_fields(); req_valid = '1; tick(); end
    req_valid = '0; repeat (L + 1) tick();

    // Two accepts, flush one cycle later, INIT again, then a fresh op.
    rand_fields(); req_valid = '0; set_req(2, 18'd100, 18'd200, 18'd300, 1'b0); tick();
    req_valid = '0; set_req(3, 18'd7, 18'd8, 18'd9, 1'b1); tick();
    req_valid = '0; flush = 1'b1; tick();
    flush = 1'b0;
    chk("flush_rsp", 64'(rsp_valid), 64'd0);
    repeat (L + 1) begin req_valid = '1; tick(); end
    req_valid = '0; set_req(1, 18'd1, 18'd2, 18'd3, 1'b0); tick();
    req_valid = '0; repeat (L + 1) tick();

    // Random traffic with occasional flushes.
    repeat (300) begin
      rand_fields();
      req_valid = N'($urandom);
      flush = ($urandom_range(0, 39) == 0);
      tick();
    end
    flush = 1'b0; req_valid = '0;
    repeat (L + 2) tick();

    // Reset together with flush and requests while ops are in flight.
    repeat (2) begin rand_fields(); req_valid = '1; tick(); end
    reset = 1'b1; flush = 1'b1; req_valid = '1; tick();
    reset = 1'b0; flush = 1'b0; req_valid = '0;
    chk("post_reset_rsp", 64'(rsp_valid), 64'd0);
    chk("post_reset_dsp_reset", 64'(dsp_reset), 64'd1);
    repeat (L + 1) tick();
    repeat (6) begin rand_fields(); req_valid = N'($urandom); tick(); end
    req_valid = '0; repeat (L + 2) tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dsp_add3_arbiter.md
DSP_ADD3_ARBITER -- requirements
Module: dsp_add3_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one 3-input DSP adder (legal 2..8).
REQ-002 SHALL have parameter LATENCY, default 2, pipeline latency of the shared adder in cycles (legal 1..8).
REQ-003 SHALL have derived localparam ID_W = max(1, clog2(NUM_REQ)), requester tag width.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 reset  in  1  synchronous, active-high block reset.
REQ-007 flush  in  1  synchronous; drops in-flight ops and re-enters INIT.
REQ-008 req_valid  in  NUM_REQ  per-requester operation valid.
REQ-009 req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
REQ-010 req_op0, req_op1, req_op2  in  18*NUM_REQ each  signed operands, requester i at bits [18*i+17:18*i].
REQ-011 req_cin  in  NUM_REQ  per-requester compensate carry.
REQ-012 dsp_reset  out  1  reset to the shared adder.
REQ-013 dsp_op0, dsp_op1, dsp_op2  out  18 each  operands to the adder; dsp_cin  out  1  carry to the adder.
REQ-014 dsp_result  in  48  adder result, valid LATENCY cycles after operand presentation.
REQ-015 rsp_valid  out  1; rsp_id  out  ID_W; rsp_result  out  48  response stream, no backpressure.
REQ-016 init_done  out  1  high in RUN state.

Function
REQ-017 SHALL implement states INIT and RUN; INIT holds dsp_reset=1 for exactly LATENCY+1 cycles via a counter, then moves to RUN.
REQ-018 In INIT: req_ready=0, init_done=0, dsp operands and dsp_cin=0.
REQ-019 In RUN: dsp_reset=0, init_done=1; at most one requester granted per cycle.
REQ-020 SHALL grant combinationally from req_valid: req_ready[g]=1 only for the winner g; req_ready[g] does not depend on req_ready.
REQ-021 Accept occurs when req_valid[g] && req_ready[g]; in that cycle dsp_op0/1/2 and dsp_cin SHALL equal requester g's fields unmodified.
REQ-022 No accept in a cycle -> dsp operands and dsp_cin driven 0.
REQ-023 SHALL carry {valid, id} through a LATENCY-deep tag shift register; an op accepted at cycle t SHALL produce rsp_valid=1, rsp_id=g at cycle t+LATENCY.
REQ-024 rsp_result SHALL equal dsp_result when rsp_valid=1, else 0.
REQ-025 Back-to-back accepts every cycle SHALL yield back-to-back responses in accept order, with no gaps and no reordering.
REQ-026 flush in RUN -> INIT next cycle, tag register cleared, no rsp_valid for dropped ops; flush in INIT restarts the counter.
REQ-027 flush coincident with a valid request -> no accept that cycle.
REQ-028 reset and flush asserted together -> reset behaviour applies.

Reset
REQ-029 reset SHALL force state INIT, counter=0, priority pointer=0, and tag register cleared.
REQ-030 During and after reset: dsp_reset=1, req_ready=0, rsp_valid=0, rsp_id=0, rsp_result=0, init_done=0, and dsp operands 0.
REQ-031 reset mid-operation SHALL drop all in-flight ops with no response emitted.

Configuration
REQ-032 Macro DSP_ADD3_ARB_RR_EN defined -> round-robin arbitration.
REQ-033 Under DSP_ADD3_ARB_RR_EN: search starts at pointer p; after an accept by g, p becomes (g+1) mod NUM_REQ; with no accept, p is unchanged.
REQ-034 Macro DSP_ADD3_ARB_RR_EN undefined -> fixed priority, lowest index wins; no pointer register is present.

Verification
REQ-035 Release reset with LATENCY=2 -> dsp_reset high for 3 cycles, then init_done=1; req_ready=0 throughout INIT.
REQ-036 Requester 1 sends op0=5, op1=-3, op2=10, cin=1 -> rsp_valid 2 cycles later with rsp_id=1 and rsp_result=13.
REQ-037 RR_EN defined, all 4 requesters valid continuously -> grants 0,1,2,3,0,... and rsp_id follows the same order every cycle. RR_EN undefined -> requester 0 is granted every cycle.
REQ-038 Operands 0x1FFFF on all three inputs with cin=1, then 0x20000 on all three with cin=0 -> rsp_result=393214, then -393216, sign-extended to 48 bits.
REQ-039 flush one cycle after two accepts -> no rsp_valid for either op; INIT re-entered for LATENCY+1 cycles; the next accepted op responds correctly.
REQ-040 reset asserted while ops are in flight, coincident with flush and req_valid -> no accept, no rsp_valid, and all outputs at reset values the next cycle.
